// File: rtl/pin_capture_fifo.sv
// Captures asynchronous SAM D21 pin data on iLATCH rising edges into a small FIFO.
// Define PIN_DEGLITCH_EN to require strobes to be high for two synchronized cycles.
module pin_capture_fifo #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     iCLK,
    input  logic                     iRESET,
    input  logic [4:0]               iDIN,
    input  logic                     iLATCH,
    input  logic                     iPULSE,
    output logic [4:0]               oDAT,
    output logic                     oVALID,
    input  logic                     iREADY,
    output logic [$clog2(DEPTH):0]   oCOUNT,
    output logic                     oOVF
);

    localparam int unsigned DW = 5;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = DW + 2;
`ifdef PIN_DEGLITCH_EN
    localparam int unsigned HIST = 3;
`else
    localparam int unsigned HIST = 2;
`endif
    localparam int unsigned FILL = SYNC_STAGES + HIST;

    logic [SW-1:0]   syncQ [SYNC_STAGES];
    logic [SW-1:0]   syncOut;
    logic [HIST-1:0] latchHist;
    logic [HIST-1:0] pulseHist;
    logic [DW-1:0]   dinCur;
    logic [FILL-1:0] fillQ;
    logic            primed;
    logic            latchRise;
    logic            pulseRise;
    logic            pushReq;
    logic [DW-1:0]   pushDat;

    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;

    logic            empty;
    logic            full;
    logic            doPop;
    logic            doPush;
    logic            drop;
    logic [PW-1:0]   rdNext;
    logic [PW-1:0]   wrNext;
    logic [CW-1:0]   cntNext;
    logic [DW-1:0]   headNext;

    assign syncOut = syncQ[SYNC_STAGES-1];
    assign primed  = fillQ[FILL-1];

    // Shared synchronizer for {iPULSE, iLATCH, iDIN}
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                syncQ[i] <= '0;
            end
        end else begin
            syncQ[0] <= {iPULSE, iLATCH, iDIN};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                syncQ[i] <= syncQ[i-1];
            end
        end
    end

    // Strobe history for edge detection; fillQ marks when the history holds real samples,
    // so a strobe already high at reset release is not mistaken for an edge.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            latchHist <= '0;
            pulseHist <= '0;
            dinCur    <= '0;
            fillQ     <= '0;
        end else begin
            latchHist <= {latchHist[HIST-2:0], syncOut[DW]};
            pulseHist <= {pulseHist[HIST-2:0], syncOut[DW+1]};
            dinCur    <= syncOut[DW-1:0];
            fillQ     <= {fillQ[FILL-2:0], 1'b1};
        end
    end

`ifdef PIN_DEGLITCH_EN
    assign latchRise = primed & latchHist[0] & latchHist[1] & ~latchHist[2];
    assign pulseRise = primed & pulseHist[0] & pulseHist[1] & ~pulseHist[2];
`else
    assign latchRise = primed & latchHist[0] & ~latchHist[1];
    assign pulseRise = primed & pulseHist[0] & ~pulseHist[1];
`endif

    // Registered push request carries the data sampled alongside the edge
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            pushReq <= 1'b0;
            pushDat <= '0;
        end else begin
            pushReq <= latchRise;
            if (latchRise) begin
                pushDat <= dinCur;
            end
        end
    end

    // Next-state FIFO bookkeeping; head is forwarded when the push lands at the read slot
    always_comb begin
        empty    = (oCOUNT == '0);
        full     = (oCOUNT == CW'(DEPTH));
        doPop    = ~empty & iREADY;
        doPush   = pushReq & (~full | doPop);
        drop     = pushReq & full & ~doPop;
        rdNext   = doPop  ? rdPtr + PW'(1) : rdPtr;
        wrNext   = doPush ? wrPtr + PW'(1) : wrPtr;
        cntNext  = oCOUNT;
        if (doPush && !doPop) begin
            cntNext = oCOUNT + CW'(1);
        end else if (doPop && !doPush) begin
            cntNext = oCOUNT - CW'(1);
        end
        headNext = '0;
        if (cntNext != '0) begin
            headNext = (doPush && (wrPtr == rdNext)) ? pushDat : mem[rdNext];
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            oCOUNT <= '0;
            oVALID <= 1'b0;
            oDAT   <= '0;
            oOVF   <= 1'b0;
        end else begin
            rdPtr  <= rdNext;
            wrPtr  <= wrNext;
            oCOUNT <= cntNext;
            oVALID <= (cntNext != '0);
            oDAT   <= headNext;
            if (drop) begin
                oOVF <= 1'b1;
            end else if (pulseRise) begin
                oOVF <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge iCLK) begin
        if (doPush) begin
            mem[wrPtr] <= pushDat;
        end
    end

endmodule
